// File: rtl/des_key_sched.sv
// DES key-schedule generator.
// Loads a 64-bit key through PC-1, then steps the C/D halves through the
// sixteen rotations and presents PC-2 round keys one per handshake, either
// K1..K16 (encrypt) or K16..K1 (decrypt).
module des_key_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    input  logic        abort,
    input  logic        rk_ready,
    output logic        rk_valid,
    output logic [47:0] round_key,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    // PC-1: FIPS 46-3 key bit numbers (1 = key[63]) feeding C1..C28, D1..D28.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: C/D bit numbers (1 = C1, 29 = D1) feeding round-key bits 1..48.
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [27:0] c;
    logic [27:0] d;
    logic        dec;
    logic [55:0] cd0;
    logic        xfer;
    logic        last;
    logic        accept;

    // The packed halves keep DES bit 1 in the MSB, so C = cd[55:28], D = cd[27:0].
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  src;
        logic [5:0]  dst;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            src    = 6'(64 - PC1[i]);
            dst    = 6'(55 - i);
            r[dst] = k[src];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  src;
        logic [5:0]  dst;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            src    = 6'(56 - PC2[j]);
            dst    = 6'(47 - j);
            r[dst] = cd[src];
        end
        return r;
    endfunction

    // Rotation amount for rounds 1..16; out-of-range rounds only occur on the
    // final transfer, where C/D are cleared instead of rotated.
    function automatic logic [1:0] shift_amt(input logic [4:0] rnd);
        return (rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic [1:0] amt);
        return (amt == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic [1:0] amt);
        return (amt == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    assign cd0       = pc1(key);
    assign round_key = pc2({c, d});
    assign accept    = (state == IDLE) && start && !abort;
    assign xfer      = rk_valid && rk_ready;
    assign last      = xfer && (round_idx == 4'd15);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: abort and the final transfer both return to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = RUN;
            RUN:  if (abort || last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs follow the state register only, never rk_ready.
    always_comb begin
        rk_valid = (state == RUN);
        busy     = (state == RUN);
    end

    // C/D halves, delivery index, latched direction and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c         <= '0;
            d         <= '0;
            dec       <= 1'b0;
            round_idx <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    // Encrypt starts at C1/D1; decrypt starts at C16/D16 == C0/D0.
                    c         <= decrypt ? cd0[55:28] : rol28(cd0[55:28], 2'd1);
                    d         <= decrypt ? cd0[27:0]  : rol28(cd0[27:0], 2'd1);
                    dec       <= decrypt;
                    round_idx <= '0;
                end
            end else if (abort) begin
                c         <= '0;
                d         <= '0;
                round_idx <= '0;
            end else if (xfer) begin
                if (round_idx == 4'd15) begin
                    c         <= '0;
                    d         <= '0;
                    round_idx <= '0;
                    done      <= 1'b1;
                end else begin
                    round_idx <= round_idx + 4'd1;
                    if (dec) begin
                        c <= ror28(c, shift_amt(5'd16 - {1'b0, round_idx}));
                        d <= ror28(d, shift_amt(5'd16 - {1'b0, round_idx}));
                    end else begin
                        c <= rol28(c, shift_amt({1'b0, round_idx} + 5'd2));
                        d <= rol28(d, shift_amt({1'b0, round_idx} + 5'd2));
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: directed scenarios with random
// keys and random back-pressure, checked against a bit-list reference model.
module tb_des_key_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        abort;
    logic        rk_ready;
    logic        rk_valid;
    logic [47:0] round_key;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [47:0] exp_enc [16];
    logic [47:0] obs     [16];
    logic [47:0] saved   [16];

    des_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .decrypt   (decrypt),
        .key       (key),
        .abort     (abort),
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Reference: Kr = PC-2 of C0/D0 rotated by the running total of shifts.
    task automatic build_model(input logic [63:0] k);
        bit          b   [65];
        bit          cd0 [57];
        bit          cc  [29];
        bit          dd  [29];
        logic [63:0] tmp;
        logic [47:0] kk;
        int          cum;
        int          p;
        tmp = k;
        for (int i = 1; i <= 64; i++) begin
            b[i] = tmp[63];
            tmp  = tmp << 1;
        end
        for (int i = 1; i <= 56; i++) cd0[i] = b[PC1_T[i-1]];
        cum = 0;
        for (int r = 0; r < 16; r++) begin
            cum += SHIFTS[r];
            for (int i = 1; i <= 28; i++) begin
                cc[i] = cd0[((i - 1 + cum) % 28) + 1];
                dd[i] = cd0[28 + ((i - 1 + cum) % 28) + 1];
            end
            kk = '0;
            for (int j = 1; j <= 48; j++) begin
                p  = PC2_T[j-1];
                kk = {kk[46:0], (p <= 28) ? cc[p] : dd[p-28]};
            end
            exp_enc[r] = kk;
        end
    endtask

    // Drive start for one edge, then scramble key/decrypt to prove they are ignored.
    task automatic issue_start(input logic [63:0] k, input logic dec);
        key     = k;
        decrypt = dec;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        key     = {$urandom, $urandom};
        decrypt = ~dec;
    endtask

    // Collect all 16 keys; returns in the cycle where done should pulse.
    task automatic collect(input logic [63:0] k, input logic dec, input bit stall, input string tg);
        int          got;
        int          cycles;
        logic [47:0] want;
        build_model(k);
        got    = 0;
        cycles = 0;
        while (got < 16 && cycles < 300) begin
            want = dec ? exp_enc[15-got] : exp_enc[got];
            chk({tg, "_valid"}, 64'(rk_valid), 64'd1);
            chk({tg, "_busy"},  64'(busy), 64'd1);
            chk({tg, "_idx"},   64'(round_idx), 64'(got));
            chk({tg, "_key"},   64'(round_key), 64'(want));
            chk({tg, "_nodone"}, 64'(done), 64'd0);
            obs[got] = round_key;
            rk_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (rk_ready) got++;
            @(negedge clk);
            cycles++;
        end
        if (got < 16) chk({tg, "_timeout"}, 64'(got), 64'd16);
        if (!stall) chk({tg, "_latency"}, 64'(cycles), 64'd16);
        chk({tg, "_done"},      64'(done), 64'd1);
        chk({tg, "_busy_end"},  64'(busy), 64'd0);
        chk({tg, "_valid_end"}, 64'(rk_valid), 64'd0);
        chk({tg, "_key_end"},   64'(round_key), 64'd0);
    endtask

    initial begin
        logic [63:0] kf;
        logic [63:0] kp;
        logic [63:0] kr;
        logic        dr;

        rst_n    = 1'b0;
        start    = 1'b0;
        decrypt  = 1'b0;
        key      = '0;
        abort    = 1'b0;
        rk_ready = 1'b0;
        kf       = 64'h133457799BBCDFF1;
        kp       = 64'h123456789ABCDEF0;

        // Reset state
        #12;
        chk("rst_valid", 64'(rk_valid), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_idx",   64'(round_idx), 64'd0);
        chk("rst_key",   64'(round_key), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS example, encrypt order
        issue_start(kf, 1'b0);
        collect(kf, 1'b0, 1'b0, "enc");
        chk("fips_k1",  64'(obs[0]),  64'h1B02EFFC7072);
        chk("fips_k16", 64'(obs[15]), 64'hCB3D8B0E17F5);
        for (int i = 0; i < 16; i++) saved[i] = obs[i];
        @(negedge clk);
        chk("done_pulse_once", 64'(done), 64'd0);

        // Same key, decrypt order: exact reverse
        issue_start(kf, 1'b1);
        collect(kf, 1'b1, 1'b0, "dec");
        chk("dec_first", 64'(obs[0]),  64'hCB3D8B0E17F5);
        chk("dec_last",  64'(obs[15]), 64'h1B02EFFC7072);
        for (int i = 0; i < 16; i++) chk("dec_reverse", 64'(obs[i]), 64'(saved[15-i]));
        @(negedge clk);

        // Parity bits ignored, random stalls
        issue_start(kp, 1'b0);
        collect(kp, 1'b0, 1'b0, "par_a");
        for (int i = 0; i < 16; i++) saved[i] = obs[i];
        @(negedge clk);
        issue_start(kp ^ 64'h0101010101010101, 1'b0);
        collect(kp ^ 64'h0101010101010101, 1'b0, 1'b1, "par_b");
        for (int i = 0; i < 16; i++) chk("parity_same", 64'(obs[i]), 64'(saved[i]));
        @(negedge clk);

        // Abort at index 7 with a transfer in the same cycle
        issue_start(kf, 1'b0);
        build_model(kf);
        rk_ready = 1'b1;
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk("abort_idx7", 64'(round_idx), 64'd7);
        chk("abort_key7", 64'(round_key), 64'(exp_enc[7]));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", 64'(rk_valid), 64'd0);
        chk("abort_busy",  64'(busy), 64'd0);
        chk("abort_done",  64'(done), 64'd0);
        chk("abort_key",   64'(round_key), 64'd0);
        @(negedge clk);
        chk("abort_nodone", 64'(done), 64'd0);
        issue_start(kp, 1'b1);
        collect(kp, 1'b1, 1'b0, "after_abort");
        @(negedge clk);

        // Asynchronous reset at index 5
        issue_start(kf, 1'b1);
        rk_ready = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("ar_idx5", 64'(round_idx), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(rk_valid), 64'd0);
        chk("ar_busy",  64'(busy), 64'd0);
        chk("ar_idx",   64'(round_idx), 64'd0);
        chk("ar_key",   64'(round_key), 64'd0);
        chk("ar_done",  64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Start while running is ignored
        issue_start(kf, 1'b0);
        build_model(kf);
        rk_ready = 1'b0;
        chk("sir_idx0", 64'(round_idx), 64'd0);
        start   = 1'b1;
        key     = kp;
        decrypt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("sir_idx_hold", 64'(round_idx), 64'd0);
        chk("sir_key_hold", 64'(round_key), 64'(exp_enc[0]));
        chk("sir_valid",    64'(rk_valid), 64'd1);
        rk_ready = 1'b1;
        @(negedge clk);
        chk("sir_idx1", 64'(round_idx), 64'd1);
        chk("sir_key1", 64'(round_key), 64'(exp_enc[1]));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);

        // Start in the done cycle: back-to-back schedules
        issue_start(kp, 1'b0);
        collect(kp, 1'b0, 1'b0, "chain_a");
        issue_start(kf, 1'b1);
        collect(kf, 1'b1, 1'b0, "chain_b");
        @(negedge clk);

        // All-zero key in both modes
        issue_start(64'd0, 1'b0);
        collect(64'd0, 1'b0, 1'b0, "zero_enc");
        chk("zero_enc_k8", 64'(obs[8]), 64'd0);
        @(negedge clk);
        issue_start(64'd0, 1'b1);
        collect(64'd0, 1'b1, 1'b1, "zero_dec");
        chk("zero_dec_k3", 64'(obs[3]), 64'd0);
        @(negedge clk);

        // Random keys, random direction, random stalls
        for (int n = 0; n < 4; n++) begin
            kr = {$urandom, $urandom};
            dr = ($urandom_range(0, 1) == 1);
            issue_start(kr, dr);
            collect(kr, dr, 1'b1, "rand");
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
